// File: rtl/blink_pattern_monitor_pkg.sv
// Shared types and helpers for the blink pattern monitor: pattern class codes,
// sequence-tracker FSM states and the saturating 8-bit increment.
package blink_pattern_monitor_pkg;

  typedef enum logic [2:0] {
    CLS_ZERO   = 3'd0,
    CLS_ONEHOT = 3'd1,
    CLS_MASK   = 3'd2,
    CLS_FULL   = 3'd3,
    CLS_NIB_LO = 3'd4,
    CLS_NIB_HI = 3'd5,
    CLS_OTHER  = 3'd6
  } pat_class_t;

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_TRACK = 2'd1,
    ST_LOCK  = 2'd2
  } state_t;

  localparam logic [7:0] SAT_MAX = 8'hFF;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == SAT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pattern_classify.sv
// Pure combinational classifier: class of the incoming word and whether the
// step from the previously accepted word is a legal generator transition.
module pattern_classify
  import blink_pattern_monitor_pkg::*;
(
  input  logic [7:0] word,
  input  logic [7:0] prev,
  output pat_class_t word_class,
  output logic       legal
);

  pat_class_t prev_class;
  logic [7:0] shl;
  logic [7:0] shr;

  // Priority order matters: 80 is ONEHOT, and F0 is a MSB mask before NIB_HI.
  function automatic pat_class_t classify(input logic [7:0] w);
    logic [7:0] inv;
    inv = ~w;
    if (w == 8'h00)                                       return CLS_ZERO;
    else if ($countones(w) == 1)                          return CLS_ONEHOT;
    else if (w != 8'hFF && (inv & (inv + 8'd1)) == 8'h00) return CLS_MASK;
    else if (w == 8'hFF)                                  return CLS_FULL;
    else if (w == 8'h0F)                                  return CLS_NIB_LO;
    else if (w == 8'hF0)                                  return CLS_NIB_HI;
    else                                                  return CLS_OTHER;
  endfunction

  always_comb begin
    prev_class = classify(prev);
    word_class = classify(word);
    shl        = {prev[6:0], 1'b0};
    shr        = {1'b0, prev[7:1]};
    legal      = 1'b0;
    if (prev_class == CLS_OTHER || word_class == CLS_OTHER)
      legal = 1'b0;
    else if (prev_class == CLS_ZERO || word_class == CLS_ZERO)
      legal = 1'b1;
    else if (prev_class == CLS_ONEHOT && word_class == CLS_ONEHOT &&
             (word == shl || word == shr))
      legal = 1'b1;
    else if (prev == 8'hFF && word == 8'hFE)
      legal = 1'b1;
    else if (prev_class == CLS_MASK &&
             (word_class == CLS_MASK || word_class == CLS_ONEHOT) && word == shl)
      legal = 1'b1;
    // Nibble blink is matched on the words since F0 classifies as a mask.
    else if ((prev == 8'h0F && word == 8'hF0) || (prev == 8'hF0 && word == 8'h0F))
      legal = 1'b1;
    else if (prev == 8'h01 && word == 8'h80)
      legal = 1'b1;
  end

endmodule

// File: rtl/blink_pattern_monitor.sv
// Receive-side LED pattern monitor: synchronizes and debounces the pattern bus,
// classifies each newly stable word and tracks sequence legality and lock.
module blink_pattern_monitor
  import blink_pattern_monitor_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int STABLE_CYC = 16,
  parameter int LOCK_N     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pat_in,
  output logic             pat_valid,
  output logic [WIDTH-1:0] pat_word,
  output logic [2:0]       pat_class,
  output logic [7:0]       run_len,
  output logic             locked,
  output logic [7:0]       err_cnt,
  output state_t           state_dbg
);

  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam int LW = $clog2(LOCK_N + 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [CW-1:0]    stab_cnt;
  logic             accept;
  pat_class_t       new_class;
  logic             legal;
  state_t           state_q;
  state_t           state_d;
  logic [LW-1:0]    lcnt_q;
  logic [LW-1:0]    lcnt_d;
  logic             err_inc;

  pattern_classify u_classify (
    .word       (s2),
    .prev       (pat_word),
    .word_class (new_class),
    .legal      (legal)
  );

  // A word that re-stabilises to the last accepted value is not a new word.
  assign accept    = (stab_cnt == CW'(STABLE_CYC - 1)) && (s2 != pat_word);
  assign locked    = (state_q == ST_LOCK);
  assign state_dbg = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_HUNT;
      lcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      lcnt_q  <= lcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lcnt_d  = lcnt_q;
    err_inc = 1'b0;
    if (accept) begin
      case (state_q)
        ST_HUNT: begin
          state_d = ST_TRACK;
          lcnt_d  = '0;
        end
        ST_TRACK: begin
          if (legal) begin
            if (lcnt_q == LW'(LOCK_N - 1)) begin
              state_d = ST_LOCK;
              lcnt_d  = '0;
            end else begin
              lcnt_d = lcnt_q + LW'(1);
            end
          end else begin
            err_inc = 1'b1;
            lcnt_d  = '0;
          end
        end
        ST_LOCK: begin
          if (!legal) begin
            err_inc = 1'b1;
            state_d = ST_TRACK;
            lcnt_d  = '0;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1        <= '0;
      s2        <= '0;
      stab_cnt  <= '0;
      pat_valid <= 1'b0;
      pat_word  <= '0;
      pat_class <= '0;
      run_len   <= '0;
      err_cnt   <= '0;
    end else begin
      s1 <= pat_in;
      s2 <= s1;
      // s1 != s2 means s2 changes on this edge, so the count restarts with it.
      if (s1 != s2)
        stab_cnt <= '0;
      else if (stab_cnt != CW'(STABLE_CYC))
        stab_cnt <= stab_cnt + CW'(1);
      pat_valid <= accept;
      if (accept) begin
        pat_word  <= s2;
        pat_class <= new_class;
        run_len   <= (pat_class == 3'(new_class) && run_len != 8'd0) ? sat_inc(run_len) : 8'd1;
        if (err_inc)
          err_cnt <= sat_inc(err_cnt);
      end
    end
  end

endmodule
